// File: rtl/gpu_frame_sequencer.sv
// Avalon-MM master that renders a whole frame on the voxel GPU, one shader-sized chunk at a time.
// Optional irq watchdog is enabled by defining GPU_SEQ_TIMEOUT_EN.
module gpu_frame_sequencer #(
  parameter int          H_RESOLUTION   = 320,
  parameter int          V_RESOLUTION   = 240,
  parameter int          NUM_SHADERS    = 320,
  parameter int          MEM_ADDR_BITS  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [MEM_ADDR_BITS-1:0] num_voxels,
  input  logic [7:0]               num_palette,
  input  logic [31:0]              fb_base,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic                     mem_sel,
  output logic                     mem_rd,
  input  logic [31:0]              mem_data,
  output logic [7:0]               m_address,
  output logic                     m_read,
  output logic                     m_write,
  output logic [31:0]              m_writedata,
  input  logic [31:0]              m_readdata,
  input  logic                     m_waitrequest,
  input  logic                     irq
);

  localparam int TOTAL_PIXELS = H_RESOLUTION * V_RESOLUTION;
  localparam int COL_BITS     = $clog2(H_RESOLUTION);

  typedef enum logic [3:0] {
    IDLE, COORD, FETCH, FETCH_WAIT, RAST, SHADE, PIXEL, WAIT_IRQ, ACK, CLEAR_ERR
  } state_t;

  typedef enum logic [1:0] {PH_COORD, PH_VOX, PH_PAL, PH_PIX} phase_t;

  state_t                   r_state, w_nextState;
  phase_t                   r_phase, w_nextPhase;
  logic [31:0]              r_idx, w_nextIdx;
  logic [31:0]              r_startPixel, r_row, r_col;
  logic [MEM_ADDR_BITS-1:0] r_numVoxels;
  logic [7:0]               r_numPalette;
  logic [31:0]              r_fbBase, r_fetched;
  logic                     r_busy, r_done, r_error;
  logic                     w_accept, w_capture, w_pixStep, w_chunkEnd, w_finish, w_abort, w_release;
  logic [31:0]              w_idxNext, w_pixLeft, w_chunkLen, w_pixAddr;
  logic                     w_lastVox, w_lastPal, w_lastPix, w_frameEnd;
`ifdef GPU_SEQ_TIMEOUT_EN
  logic [31:0]              r_wdog;
`endif

  assign w_idxNext  = r_idx + 32'd1;
  assign w_pixLeft  = 32'(TOTAL_PIXELS) - r_startPixel;
  assign w_chunkLen = (w_pixLeft < 32'(NUM_SHADERS)) ? w_pixLeft : 32'(NUM_SHADERS);
  assign w_lastVox  = w_idxNext >= 32'(r_numVoxels);
  assign w_lastPal  = w_idxNext >= 32'(r_numPalette);
  assign w_lastPix  = w_idxNext >= w_chunkLen;
  assign w_frameEnd = (r_startPixel + 32'(NUM_SHADERS)) >= 32'(TOTAL_PIXELS);
  // Framebuffer is laid out with a power-of-two row pitch of 16-bit pixels.
  assign w_pixAddr  = r_fbBase + (r_row << (COL_BITS + 1)) + (r_col << 1);

  assign busy  = r_busy;
  assign done  = r_done;
  assign error = r_error;

  always_comb begin
    w_nextState = r_state;
    w_nextPhase = r_phase;
    w_nextIdx   = r_idx;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_pixStep   = 1'b0;
    w_chunkEnd  = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    w_release   = 1'b0;
    m_address   = 8'h00;
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_writedata = 32'd0;
    mem_rd      = 1'b0;
    mem_sel     = 1'b0;
    mem_addr    = '0;
    case (r_state)
      IDLE: begin
        // A start coinciding with the done pulse belongs to the old frame and is dropped.
        if (start && !r_done) begin
          w_accept    = 1'b1;
          w_nextState = COORD;
          w_nextPhase = PH_COORD;
          w_nextIdx   = 32'd0;
        end
      end
      COORD: begin
        m_write     = 1'b1;
        m_address   = 8'h03;
        m_writedata = r_startPixel;
        if (!m_waitrequest) w_nextState = WAIT_IRQ;
      end
      FETCH: begin
        mem_rd      = 1'b1;
        mem_sel     = (r_phase == PH_PAL);
        mem_addr    = r_idx[MEM_ADDR_BITS-1:0];
        w_nextState = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        w_capture   = 1'b1;
        w_nextState = (r_phase == PH_PAL) ? SHADE : RAST;
      end
      RAST, SHADE, PIXEL: begin
        m_write     = 1'b1;
        m_address   = (r_state == RAST) ? 8'h00 : (r_state == SHADE) ? 8'h01 : 8'h02;
        m_writedata = (r_state == PIXEL) ? w_pixAddr : r_fetched;
        if (!m_waitrequest) w_nextState = WAIT_IRQ;
      end
      WAIT_IRQ: begin
        if (irq) w_nextState = ACK;
`ifdef GPU_SEQ_TIMEOUT_EN
        else if (r_wdog >= 32'(TIMEOUT_CYCLES) - 32'd1) begin
          w_abort     = 1'b1;
          w_nextState = CLEAR_ERR;
        end
`endif
      end
      ACK: begin
        m_read    = 1'b1;
        m_address = 8'h0f;
        if (!m_waitrequest) begin
          if (m_readdata != 32'd0) begin
            w_abort     = 1'b1;
            w_nextState = CLEAR_ERR;
          end else begin
            // Each loop hands over to the next non-empty loop; the pixel loop is never empty.
            w_nextIdx = 32'd0;
            if (r_phase == PH_COORD && r_numVoxels != '0) begin
              w_nextPhase = PH_VOX;
              w_nextState = FETCH;
            end else if (r_phase == PH_VOX && !w_lastVox) begin
              w_nextIdx   = w_idxNext;
              w_nextState = FETCH;
            end else if ((r_phase == PH_COORD || r_phase == PH_VOX) && r_numPalette != 8'd0) begin
              w_nextPhase = PH_PAL;
              w_nextState = FETCH;
            end else if (r_phase == PH_PAL && !w_lastPal) begin
              w_nextIdx   = w_idxNext;
              w_nextState = FETCH;
            end else if (r_phase != PH_PIX) begin
              w_nextPhase = PH_PIX;
              w_nextState = PIXEL;
            end else begin
              w_pixStep = 1'b1;
              if (!w_lastPix) begin
                w_nextIdx   = w_idxNext;
                w_nextState = PIXEL;
              end else begin
                w_chunkEnd  = 1'b1;
                w_nextPhase = PH_COORD;
                if (w_frameEnd) begin
                  w_finish    = 1'b1;
                  w_nextState = IDLE;
                end else begin
                  w_nextState = COORD;
                end
              end
            end
          end
        end
      end
      CLEAR_ERR: begin
        m_write     = 1'b1;
        m_address   = 8'h0f;
        m_writedata = 32'd1;
        if (!m_waitrequest) begin
          w_release   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_phase      <= PH_COORD;
      r_idx        <= 32'd0;
      r_startPixel <= 32'd0;
      r_row        <= 32'd0;
      r_col        <= 32'd0;
      r_numVoxels  <= '0;
      r_numPalette <= 8'd0;
      r_fbBase     <= 32'd0;
      r_fetched    <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_phase <= w_nextPhase;
      r_idx   <= w_nextIdx;
      r_done  <= w_finish;
      if (w_accept) begin
        r_numVoxels  <= num_voxels;
        r_numPalette <= num_palette;
        r_fbBase     <= fb_base;
        r_startPixel <= 32'd0;
        r_row        <= 32'd0;
        r_col        <= 32'd0;
        r_busy       <= 1'b1;
        r_error      <= 1'b0;
      end
      if (w_capture) r_fetched <= mem_data;
      if (w_pixStep) begin
        if (r_col == 32'(H_RESOLUTION - 1)) begin
          r_col <= 32'd0;
          r_row <= r_row + 32'd1;
        end else begin
          r_col <= r_col + 32'd1;
        end
      end
      if (w_chunkEnd) r_startPixel <= r_startPixel + 32'(NUM_SHADERS);
      if (w_abort) r_error <= 1'b1;
      if (w_finish || w_release) r_busy <= 1'b0;
    end
  end

`ifdef GPU_SEQ_TIMEOUT_EN
  // Restarts from zero on every entry because any other state clears it.
  always_ff @(posedge clock) begin
    if (reset) r_wdog <= 32'd0;
    else       r_wdog <= (r_state == WAIT_IRQ) ? r_wdog + 32'd1 : 32'd0;
  end
`endif

endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// Directed bench for gpu_frame_sequencer: two small-frame instances share one reactive GPU/memory model.
// Build with GPU_SEQ_TIMEOUT_EN defined to also exercise the irq watchdog.
module tb_gpu_frame_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, sel;
  logic [15:0] numVoxels;
  logic [7:0]  numPalette;
  logic [31:0] fbBase, memData, readData;
  logic        waitReq, irq;

  logic        aBusy, aDone, aError, aMemSel, aMemRd, aRd, aWr;
  logic [15:0] aMemAddr;
  logic [7:0]  aAddr;
  logic [31:0] aWdata;
  logic        bBusy, bDone, bError, bMemSel, bMemRd, bRd, bWr;
  logic [15:0] bMemAddr;
  logic [7:0]  bAddr;
  logic [31:0] bWdata;

  logic        wBusy, wDone, wError, wMemSel, wMemRd, wRd, wWr;
  logic [15:0] wMemAddr;
  logic [7:0]  wAddr;
  logic [31:0] wWdata;

  int checkCount = 0;
  int errorCount = 0;

  int  stallCycles, stallCnt, irqTimer, rastCnt;
  bit  irqEnable, errMode;
  int  writeCount, readCount, doneCount, stableErr, conflictErr, clearCount;
  logic [7:0]  snapAddr, lastWAddr;
  logic [31:0] snapData, lastWData;
  logic        snapRd, snapWr, errAtStart, busyAtStart;
  logic [31:0] coordQ[$], rastQ[$], shadeQ[$], pixQ[$];

  always #5 clock = ~clock;

  gpu_frame_sequencer #(.H_RESOLUTION(4), .V_RESOLUTION(2), .NUM_SHADERS(4),
                        .MEM_ADDR_BITS(16), .TIMEOUT_CYCLES(10)) dutA (
    .clock(clock), .reset(reset), .start(start && !sel), .num_voxels(numVoxels),
    .num_palette(numPalette), .fb_base(fbBase), .busy(aBusy), .done(aDone), .error(aError),
    .mem_addr(aMemAddr), .mem_sel(aMemSel), .mem_rd(aMemRd), .mem_data(memData),
    .m_address(aAddr), .m_read(aRd), .m_write(aWr), .m_writedata(aWdata),
    .m_readdata(readData), .m_waitrequest(waitReq), .irq(irq));

  gpu_frame_sequencer #(.H_RESOLUTION(3), .V_RESOLUTION(2), .NUM_SHADERS(4),
                        .MEM_ADDR_BITS(16), .TIMEOUT_CYCLES(10)) dutB (
    .clock(clock), .reset(reset), .start(start && sel), .num_voxels(numVoxels),
    .num_palette(numPalette), .fb_base(fbBase), .busy(bBusy), .done(bDone), .error(bError),
    .mem_addr(bMemAddr), .mem_sel(bMemSel), .mem_rd(bMemRd), .mem_data(memData),
    .m_address(bAddr), .m_read(bRd), .m_write(bWr), .m_writedata(bWdata),
    .m_readdata(readData), .m_waitrequest(waitReq), .irq(irq));

  assign wBusy    = sel ? bBusy    : aBusy;
  assign wDone    = sel ? bDone    : aDone;
  assign wError   = sel ? bError   : aError;
  assign wMemSel  = sel ? bMemSel  : aMemSel;
  assign wMemRd   = sel ? bMemRd   : aMemRd;
  assign wMemAddr = sel ? bMemAddr : aMemAddr;
  assign wRd      = sel ? bRd      : aRd;
  assign wWr      = sel ? bWr      : aWr;
  assign wAddr    = sel ? bAddr    : aAddr;
  assign wWdata   = sel ? bWdata   : aWdata;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    writeCount = 0; readCount = 0; doneCount = 0; stableErr = 0; conflictErr = 0;
    clearCount = 0; rastCnt = 0; lastWAddr = 8'h00; lastWData = 32'd0;
    coordQ.delete(); rastQ.delete(); shadeQ.delete(); pixQ.delete();
  endtask

  task automatic resetModel();
    waitReq = 1'b0; irq = 1'b0; irqTimer = 0; stallCnt = 0; readData = 32'd0;
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] nv, input logic [7:0] np,
                               input logic [31:0] fb);
    int n;
    @(negedge clock);
    sel = s; numVoxels = nv; numPalette = np; fbBase = fb; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    errAtStart  = wError;
    busyAtStart = wBusy;
    n = 0;
    while (wBusy && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20000) checkOutput("frameTimeout", 32'd1, 32'd0);
    repeat (3) @(negedge clock);
  endtask

  // GPU register slave and voxel/palette memory, evaluated on the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      resetModel();
    end else begin
      if (wDone) doneCount++;
      if (wRd && wWr) conflictErr++;
      if (wMemRd) memData = wMemSel ? (32'hA000_0000 | 32'(wMemAddr)) : (32'h5000_0000 | 32'(wMemAddr));
      if (irqTimer > 0) begin
        irqTimer--;
        if (irqTimer == 0) irq = 1'b1;
      end
      if (wRd || wWr) begin
        if (stallCnt == 0) begin
          snapAddr = wAddr; snapData = wWdata; snapRd = wRd; snapWr = wWr;
        end else if (snapAddr !== wAddr || snapData !== wWdata || snapRd !== wRd || snapWr !== wWr) begin
          stableErr++;
        end
        if (stallCnt < stallCycles) begin
          waitReq = 1'b1;
          stallCnt++;
        end else begin
          waitReq  = 1'b0;
          stallCnt = 0;
          if (wWr) begin
            writeCount++;
            lastWAddr = wAddr;
            lastWData = wWdata;
            case (wAddr)
              8'h03: coordQ.push_back(wWdata);
              8'h00: begin rastQ.push_back(wWdata); rastCnt++; end
              8'h01: shadeQ.push_back(wWdata);
              8'h02: pixQ.push_back(wWdata);
              8'h0f: clearCount++;
              default: ;
            endcase
            if (wAddr != 8'h0f && irqEnable) irqTimer = 3;
          end else begin
            readCount++;
            irq = 1'b0;
            readData = (errMode && rastCnt == 2) ? 32'd2 : 32'd0;
            if (errMode && rastCnt == 2) errMode = 1'b0;
          end
        end
      end else begin
        waitReq  = 1'b0;
        stallCnt = 0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL globalTimeout: simulation did not complete");
    $fatal(1, "[TB] global time limit reached");
  end

  initial begin
    reset = 1'b1; start = 1'b0; sel = 1'b0; numVoxels = 16'd0; numPalette = 8'd0; fbBase = 32'd0;
    memData = 32'd0; stallCycles = 0; irqEnable = 1'b1; errMode = 1'b0;
    resetModel();
    clearLog();
    repeat (3) @(negedge clock);
    checkOutput("rstBusy",   {31'd0, wBusy}, 32'd0);
    checkOutput("rstDone",   {31'd0, wDone}, 32'd0);
    checkOutput("rstError",  {31'd0, wError}, 32'd0);
    checkOutput("rstStrobe", {29'd0, wRd, wWr, wMemRd}, 32'd0);
    checkOutput("rstAddr",   {8'd0, wAddr, wMemAddr}, 32'd0);
    checkOutput("rstWdata",  wWdata, 32'd0);
    reset = 1'b0;

    // Basic frame: two 4-pixel chunks, 2 voxels, 1 palette entry.
    clearLog();
    applyStimulus(1'b0, 16'd2, 8'd1, 32'h0000_1000);
    checkOutput("basicWrites", 32'(writeCount), 32'd16);
    checkOutput("basicReads",  32'(readCount), 32'd16);
    checkOutput("basicCoordN", 32'(coordQ.size()), 32'd2);
    checkOutput("basicCoord0", (coordQ.size() > 0) ? coordQ[0] : 32'hDEAD_BEEF, 32'd0);
    checkOutput("basicCoord1", (coordQ.size() > 1) ? coordQ[1] : 32'hDEAD_BEEF, 32'd4);
    checkOutput("basicDone",   32'(doneCount), 32'd1);
    checkOutput("basicError",  {31'd0, wError}, 32'd0);
    checkOutput("basicRastN",  32'(rastQ.size()), 32'd4);
    checkOutput("basicRast1",  (rastQ.size() > 1) ? rastQ[1] : 32'hDEAD_BEEF, 32'h5000_0001);
    checkOutput("basicShade0", (shadeQ.size() > 0) ? shadeQ[0] : 32'hDEAD_BEEF, 32'hA000_0000);
    checkOutput("pixCount",    32'(pixQ.size()), 32'd8);
    checkOutput("pixFirst",    (pixQ.size() > 0) ? pixQ[0] : 32'hDEAD_BEEF, 32'h0000_1000);
    checkOutput("pixRow1Col0", (pixQ.size() > 4) ? pixQ[4] : 32'hDEAD_BEEF, 32'h0000_1008);
    checkOutput("pixRow1Col3", (pixQ.size() > 7) ? pixQ[7] : 32'hDEAD_BEEF, 32'h0000_100E);

    // Same frame with five wait states on every transfer.
    clearLog();
    stallCycles = 5;
    applyStimulus(1'b0, 16'd2, 8'd1, 32'h0000_1000);
    stallCycles = 0;
    checkOutput("bpWrites",   32'(writeCount), 32'd16);
    checkOutput("bpReads",    32'(readCount), 32'd16);
    checkOutput("bpStable",   32'(stableErr), 32'd0);
    checkOutput("bpConflict", 32'(conflictErr), 32'd0);
    checkOutput("bpDone",     32'(doneCount), 32'd1);
    checkOutput("bpPixLast",  (pixQ.size() > 7) ? pixQ[7] : 32'hDEAD_BEEF, 32'h0000_100E);

    // Status 2 after the second rasterize aborts the frame.
    clearLog();
    errMode = 1'b1;
    applyStimulus(1'b0, 16'd2, 8'd1, 32'h0000_1000);
    checkOutput("errWrites",   32'(writeCount), 32'd4);
    checkOutput("errReads",    32'(readCount), 32'd3);
    checkOutput("errClearN",   32'(clearCount), 32'd1);
    checkOutput("errLastAddr", {24'd0, lastWAddr}, 32'h0000_000F);
    checkOutput("errLastData", lastWData, 32'd1);
    checkOutput("errFlag",     {31'd0, wError}, 32'd1);
    checkOutput("errNoDone",   32'(doneCount), 32'd0);
    checkOutput("errBusy",     {31'd0, wBusy}, 32'd0);

    clearLog();
    applyStimulus(1'b0, 16'd1, 8'd1, 32'h0000_1000);
    checkOutput("restartErr",  {31'd0, errAtStart}, 32'd0);
    checkOutput("restartBusy", {31'd0, busyAtStart}, 32'd1);
    checkOutput("restartDone", 32'(doneCount), 32'd1);

    // Empty voxel and palette loops.
    clearLog();
    applyStimulus(1'b0, 16'd0, 8'd0, 32'h0000_2000);
    checkOutput("emptyRast",   32'(rastQ.size()), 32'd0);
    checkOutput("emptyShade",  32'(shadeQ.size()), 32'd0);
    checkOutput("emptyWrites", 32'(writeCount), 32'd10);
    checkOutput("emptyDone",   32'(doneCount), 32'd1);
    checkOutput("emptyPix0",   (pixQ.size() > 0) ? pixQ[0] : 32'hDEAD_BEEF, 32'h0000_2000);

    // 3x2 frame with 4-pixel chunks leaves a 2-pixel final chunk.
    clearLog();
    applyStimulus(1'b1, 16'd1, 8'd1, 32'h0000_0000);
    checkOutput("partCoordN",  32'(coordQ.size()), 32'd2);
    checkOutput("partCoord1",  (coordQ.size() > 1) ? coordQ[1] : 32'hDEAD_BEEF, 32'd4);
    checkOutput("partPixN",    32'(pixQ.size()), 32'd6);
    checkOutput("partWrites",  32'(writeCount), 32'd12);
    checkOutput("partPix3",    (pixQ.size() > 3) ? pixQ[3] : 32'hDEAD_BEEF, 32'h0000_0008);
    checkOutput("partPix5",    (pixQ.size() > 5) ? pixQ[5] : 32'hDEAD_BEEF, 32'h0000_000C);
    checkOutput("partDone",    32'(doneCount), 32'd1);

    // Reset while a pixel write is on the bus.
    begin
      int n;
      clearLog();
      @(negedge clock);
      sel = 1'b0; numVoxels = 16'd1; numPalette = 8'd1; fbBase = 32'h0000_3000; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      while (!(wWr && wAddr == 8'h02) && n < 5000) begin
        @(negedge clock);
        n++;
      end
      checkOutput("midPixReached", {31'd0, (wWr && wAddr == 8'h02)}, 32'd1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("midRstFlags",  {29'd0, wBusy, wDone, wError}, 32'd0);
      checkOutput("midRstStrobe", {29'd0, wRd, wWr, wMemRd}, 32'd0);
      checkOutput("midRstAddr",   {8'd0, wAddr, wMemAddr}, 32'd0);
      checkOutput("midRstWdata",  wWdata, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      resetModel();
      repeat (2) @(negedge clock);
      resetModel();
    end

`ifdef GPU_SEQ_TIMEOUT_EN
    // irq never arrives: the watchdog aborts after 10 cycles in WAIT_IRQ.
    begin
      int n;
      clearLog();
      irqEnable = 1'b0;
      @(negedge clock);
      sel = 1'b0; numVoxels = 16'd1; numPalette = 8'd1; fbBase = 32'd0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      while (!wWr && n < 100) begin
        @(negedge clock);
        n++;
      end
      checkOutput("toCoordSeen", {31'd0, wWr}, 32'd1);
      @(posedge clock);
      repeat (9) @(posedge clock);
      #1;
      checkOutput("toErrEarly", {31'd0, wError}, 32'd0);
      @(posedge clock);
      #1;
      checkOutput("toErrSet", {31'd0, wError}, 32'd1);
      n = 0;
      while (wBusy && n < 100) begin
        @(negedge clock);
        n++;
      end
      repeat (2) @(negedge clock);
      checkOutput("toClearN",    32'(clearCount), 32'd1);
      checkOutput("toClearData", lastWData, 32'd1);
      checkOutput("toNoDone",    32'(doneCount), 32'd0);
      irqEnable = 1'b1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/gpu_frame_sequencer.md
Name: gpu_frame_sequencer

Overview:
- Avalon-MM master that drives the voxel GPU's 8-bit-address register slave. It is the initiator for that slave and removes per-command CPU work.
- On `start` it renders one full frame. The frame is processed in chunks of NUM_SHADERS pixels.
- For each chunk it issues, in order: coordinate, rasterize, shade, then write-out commands.
- After every command it waits for the GPU irq and reads the status register to clear the interrupt. It reports done or error to its own host.

Parameters:
- H_RESOLUTION, 320, frame width in pixels.
- V_RESOLUTION, 240, frame height in pixels.
- NUM_SHADERS, 320, pixels per chunk (the GPU shader count).
- MEM_ADDR_BITS, 16, width of the voxel/palette memory address.
- TIMEOUT_CYCLES, 65535, irq watchdog limit (used only with the optional feature).

Ports:
- clock in 1: the only clock.
- reset in 1: synchronous, active-high.
- start in 1: one-cycle request; ignored while busy=1.
- num_voxels in MEM_ADDR_BITS: rasterize commands per chunk; sampled at start.
- num_palette in 8: shade commands per chunk; sampled at start.
- fb_base in 32: framebuffer base byte address; sampled at start.
- busy out 1: frame in progress.
- done out 1: one-cycle pulse on successful frame completion.
- error out 1: sticky; set on abort, cleared by the next accepted start.
- mem_addr out MEM_ADDR_BITS: word address into voxel/palette memory.
- mem_sel out 1: 0 selects voxel memory, 1 selects palette memory.
- mem_rd out 1: memory read strobe.
- mem_data in 32: read data, valid exactly 1 cycle after mem_rd.
- m_address out 8: GPU register index.
- m_read out 1: Avalon read.
- m_write out 1: Avalon write.
- m_writedata out 32: Avalon write data.
- m_readdata in 32: Avalon read data, valid when m_read=1 and m_waitrequest=0.
- m_waitrequest in 1: Avalon stall.
- irq in 1: GPU interrupt, level.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy, done, error, mem_rd, m_read, m_write = 0; m_address, m_writedata, mem_addr = 0. Reset mid-frame abandons the frame immediately; no clear command is issued.
- Avalon master rules:
  - address, data and strobes are held stable while m_waitrequest=1.
  - A transfer completes on the first cycle where the strobe is high and m_waitrequest=0.
  - m_read and m_write are never asserted together.
- States: IDLE, COORD, FETCH, FETCH_WAIT, RAST, SHADE, PIXEL, WAIT_IRQ, ACK, CLEAR_ERR.
- IDLE:
  - On start: latch the inputs, set start_pixel=0, busy=1, error=0, then go to COORD.
- COORD:
  - Write reg 0x03 with data=start_pixel, then go to WAIT_IRQ.
- WAIT_IRQ:
  - Wait for irq=1, then go to ACK.
  - irq already high on entry is accepted on that cycle.
- ACK:
  - Read reg 0x0f.
  - Readdata 0: advance to the next step.
  - Readdata 1 or 2: set error=1 and go to CLEAR_ERR.
- Step order within a chunk:
  - COORD.
  - For v=0..num_voxels-1: FETCH (mem_sel=0, mem_addr=v), then RAST (write 0x00 with mem_data).
  - For p=0..num_palette-1: FETCH (mem_sel=1, mem_addr=p), then SHADE (write 0x01 with mem_data).
  - For k=0..n-1, where n = min(NUM_SHADERS, H*V − start_pixel): PIXEL (write 0x02).
- Fetched word: mem_data is captured into m_writedata in FETCH_WAIT (1-cycle latency).
- Empty loops: num_voxels=0 skips RAST entirely; num_palette=0 skips SHADE entirely.
- PIXEL address:
  - Value written is fb_base + (row << (COL_BITS+1)) + (col << 1).
  - COL_BITS = clog2(H_RESOLUTION); row and col are the current pixel's coordinates.
  - row and col are maintained by incrementing counters (col wraps at H_RESOLUTION−1 and increments row). No divider is used.
- After the last pixel's ACK:
  - start_pixel += NUM_SHADERS.
  - If start_pixel ≥ H*V: pulse done, busy=0, go to IDLE. Otherwise go to COORD.
  - The final chunk is partial when H*V is not a multiple of NUM_SHADERS.
- CLEAR_ERR: write 0x0f with data 1, then busy=0, go to IDLE with no done pulse.
- start during busy is ignored. start arriving in the same cycle as done is ignored.

Optional Feature:
- Macro: GPU_SEQ_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counts cycles spent in WAIT_IRQ and resets on each WAIT_IRQ entry.
  - When the count reaches TIMEOUT_CYCLES: error=1, go to CLEAR_ERR.
- Undefined: no counter; WAIT_IRQ waits indefinitely.

Test Plan:
- Basic frame. Setup: H=4, V=2, NUM_SHADERS=4, num_voxels=2, num_palette=1, GPU model answers irq after 3 cycles with status 0, start.
  - Expect 16 writes and 16 reads of 0x0f.
  - Expect write data to 0x03 of 0, then 4.
  - Expect one done pulse, error=0.
- Pixel addressing. Setup: fb_base=0x1000, H=4.
  - Expect the pixel (row 1, col 3) write to 0x02 to carry 0x0000100E.
  - Expect the first pixel to carry 0x00001000.
- Backpressure. Hold m_waitrequest=1 for 5 cycles on each transfer.
  - Expect m_address, m_writedata and strobes stable throughout; command count unchanged.
  - Expect no duplicate transfers.
- Error abort. Status read returns 2 after the second RAST.
  - Expect a write of 0x0f with data 1, error=1, no done, busy=0.
  - Expect the next start to clear error.
- Edge cases.
  - num_voxels=0, num_palette=0: expect no 0x00/0x01 writes.
  - H=3, V=2, NUM_SHADERS=4: expect a second chunk of 2 pixels.
  - reset asserted mid-PIXEL: expect all outputs 0 on the next cycle.
- Timeout (GPU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=10). irq never asserts.
  - Expect error=1 after 10 cycles in WAIT_IRQ, followed by a 0x0f clear write.
